// File: rtl/mcpu_pkg.sv
// Shared definitions for the MCPU ALU sequencer: default widths, ALU
// command codes, FSM state encoding and the wide-result helper.
package mcpu_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int CMD_SIZE_DEF  = 3;
  localparam int REG_ADDR_DEF  = 3;

  localparam logic [2:0] CMD_AND = 3'd0;
  localparam logic [2:0] CMD_OR  = 3'd1;
  localparam logic [2:0] CMD_XOR = 3'd2;
  localparam logic [2:0] CMD_ADD = 3'd3;
  localparam logic [2:0] CMD_LSL = 3'd4;
  localparam logic [2:0] CMD_LSR = 3'd5;
  localparam logic [2:0] CMD_MUL = 3'd6;
  localparam logic [2:0] CMD_DIV = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;
  localparam logic [2:0] ST_WB_LO = 3'd3;
  localparam logic [2:0] ST_WB_HI = 3'd4;
  localparam logic [2:0] ST_RESP  = 3'd5;

  // Commands whose upper result half is also written back.
  function automatic logic is_wide(input logic [CMD_SIZE_DEF-1:0] cmd);
    return (cmd == CMD_MUL) || (cmd == CMD_LSL);
  endfunction

endpackage

// File: rtl/mcpu_regfile.sv
// 8 x WORD_SIZE register file with asynchronous reset-to-zero.
// Ports: clk, reset; one write port (we/waddr/wdata); one observe read port
// (rd_addr/rd_data) and two operand read ports (op1_*, op2_*), all
// combinational reads.
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int REG_ADDR  = REG_ADDR_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [REG_ADDR-1:0]  waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [REG_ADDR-1:0]  rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic [REG_ADDR-1:0]  op1_addr,
  output logic [WORD_SIZE-1:0] op1_data,
  input  logic [REG_ADDR-1:0]  op2_addr,
  output logic [WORD_SIZE-1:0] op2_data
);

  logic [WORD_SIZE-1:0] mem [2**REG_ADDR];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**REG_ADDR; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rd_data  = mem[rd_addr];
  assign op1_data = mem[op1_addr];
  assign op2_data = mem[op2_addr];

endmodule

// File: rtl/mcpu_alu_sequencer.sv
// Initiator side of the MCPU ALU command interface. Accepts one request at a
// time (req_valid/req_ready), reads two operands from the internal register
// file, drives a combinational ALU for SETTLE cycles, captures result and
// carry, writes the result back (upper half too for MUL/LSL) and pulses
// rsp_valid. Ports: clk, reset (async, active-high); req_*; external register
// load wr_*; observe port rd_*; ALU drive alu_cmd/alu_in1/alu_in2 and ALU
// result alu_out/alu_cf; response rsp_*; busy.
module mcpu_alu_sequencer
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE  = CMD_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int REG_ADDR  = REG_ADDR_DEF,
  parameter int SETTLE    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CMD_SIZE-1:0]    req_cmd,
  input  logic [REG_ADDR-1:0]    req_src1,
  input  logic [REG_ADDR-1:0]    req_src2,
  input  logic [REG_ADDR-1:0]    req_dst,
  input  logic                   wr_en,
  input  logic [REG_ADDR-1:0]    wr_addr,
  input  logic [WORD_SIZE-1:0]   wr_data,
  input  logic [REG_ADDR-1:0]    rd_addr,
  output logic [WORD_SIZE-1:0]   rd_data,
  output logic [CMD_SIZE-1:0]    alu_cmd,
  output logic [WORD_SIZE-1:0]   alu_in1,
  output logic [WORD_SIZE-1:0]   alu_in2,
  input  logic [2*WORD_SIZE-1:0] alu_out,
  input  logic                   alu_cf,
  output logic                   rsp_valid,
  output logic [2*WORD_SIZE-1:0] rsp_result,
  output logic                   rsp_cf,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [2:0]           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CMD_SIZE-1:0]  cmd_p0;
  logic [REG_ADDR-1:0]  src1_p0, src2_p0, dst_p0;
  logic [2*WORD_SIZE-1:0] result_p1;
  logic                 cf_p1, err_p1;
  logic                 div_err;

  logic                 rf_we;
  logic [REG_ADDR-1:0]  rf_waddr;
  logic [WORD_SIZE-1:0] rf_wdata;
  logic [WORD_SIZE-1:0] op1_data, op2_data;

  // Carry source depends on the command class.
  function automatic logic carry_of(input logic [CMD_SIZE-1:0] cmd,
                                    input logic [2*WORD_SIZE-1:0] res,
                                    input logic cf_in);
    case (cmd)
      CMD_ADD, CMD_LSR, CMD_DIV: return |res[2*WORD_SIZE-1:WORD_SIZE];
      CMD_MUL, CMD_LSL:          return cf_in;
      default:                   return 1'b0;
    endcase
  endfunction

  mcpu_regfile #(.WORD_SIZE(WORD_SIZE), .REG_ADDR(REG_ADDR)) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .op1_addr (src1_p0),
    .op1_data (op1_data),
    .op2_addr (src2_p0),
    .op2_data (op2_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign div_err   = (alu_cmd == CMD_DIV) && (alu_in2 == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_valid) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_EXEC;
      ST_EXEC:  if (cnt == '0) state_nxt = ST_WB_LO;
      ST_WB_LO: state_nxt = (is_wide(alu_cmd) && !err_p1) ? ST_WB_HI : ST_RESP;
      ST_WB_HI: state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // External loads only in IDLE; writeback owns the port otherwise.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wr_addr;
    rf_wdata = wr_data;
    case (state)
      ST_IDLE:  rf_we = wr_en;
      ST_WB_LO: begin
        rf_we    = !err_p1;
        rf_waddr = dst_p0;
        rf_wdata = result_p1[WORD_SIZE-1:0];
      end
      ST_WB_HI: begin
        rf_we    = 1'b1;
        rf_waddr = dst_p0 + REG_ADDR'(1);
        rf_wdata = result_p1[2*WORD_SIZE-1:WORD_SIZE];
      end
      default: ;
    endcase
  end

  // Stage p0: request fields latched at accept
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      cmd_p0  <= req_cmd;
      src1_p0 <= req_src1;
      src2_p0 <= req_src2;
      dst_p0  <= req_dst;
    end
  end

  // Stage p1: ALU drive, settle count, result capture, response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_cmd    <= '0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      result_p1  <= '0;
      cf_p1      <= 1'b0;
      err_p1     <= 1'b0;
      rsp_result <= '0;
      rsp_cf     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_READ: begin
          alu_cmd <= cmd_p0;
          alu_in1 <= op1_data;
          alu_in2 <= op2_data;
          cnt     <= CNT_W'(SETTLE - 1);
        end
        ST_EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            result_p1 <= div_err ? '0 : alu_out;
            cf_p1     <= div_err ? 1'b0 : carry_of(alu_cmd, alu_out, alu_cf);
            err_p1    <= div_err;
          end
        end
        default: ;
      endcase
      // Response fields change only on entry to RESP and hold until the next.
      if (state_nxt == ST_RESP && state != ST_RESP) begin
        rsp_result <= result_p1;
        rsp_cf     <= cf_p1;
        rsp_err    <= err_p1;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_alu_sequencer.sv
module tb_mcpu_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_cmd, req_src1, req_src2, req_dst;
  logic        wr_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
  logic [2:0]  alu_cmd;
  logic [15:0] alu_in1, alu_in2;
  logic [31:0] alu_out;
  logic        alu_cf;
  logic        rsp_valid, rsp_cf, rsp_err, busy;
  logic [31:0] rsp_result;
  logic        force_cf;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mcpu_alu_sequencer dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .alu_cmd(alu_cmd), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_cf(alu_cf),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_cf(rsp_cf),
    .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; division by zero returns garbage the sequencer must mask.
  always_comb begin
    alu_out = 32'h0;
    case (alu_cmd)
      3'd0: alu_out = {16'h0, alu_in1 & alu_in2};
      3'd1: alu_out = {16'h0, alu_in1 | alu_in2};
      3'd2: alu_out = {16'h0, alu_in1 ^ alu_in2};
      3'd3: alu_out = {16'h0, alu_in1} + {16'h0, alu_in2};
      3'd4: alu_out = {16'h0, alu_in1} << alu_in2[3:0];
      3'd5: alu_out = {16'h0, alu_in1 >> alu_in2[3:0]};
      3'd6: alu_out = {16'h0, alu_in1} * {16'h0, alu_in2};
      default: alu_out = (alu_in2 == 16'h0) ? 32'hDEAD_BEEF
                                            : {alu_in1 % alu_in2, alu_in1 / alu_in2};
    endcase
    alu_cf = force_cf;
  end

  typedef struct {
    logic [2:0]  cmd;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  dst;
    logic [31:0] res;
    logic        cf;
    logic [15:0] lo;
    logic [15:0] hi;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wreg(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rreg(input logic [2:0] a, output logic [15:0] d);
    rd_addr = a;
    #1;
    d = rd_data;
  endtask

  // Issues one op; lat = cycles from the accept edge to the rsp_valid cycle.
  task automatic do_op(input logic [2:0] cmd, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input bit poke, output int lat);
    int k;
    @(negedge clk);
    req_cmd = cmd; req_src1 = s1; req_src2 = s2; req_dst = d; req_valid = 1'b1;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    if (!req_ready) begin
      chk("accept_timeout", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    k = 0;
    while (!rsp_valid && k < 40) begin
      @(negedge clk);
      k++;
      if (poke && k == 1) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBEEF; end
      if (poke && k == 2) wr_en = 1'b0;
    end
    lat = rsp_valid ? k : -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] rv;
    int lat, na, rsp1, i, k;
    int acc[2];

    vecs[0] = '{3'd3, 16'hFFFF, 16'h0001, 3'd3, 32'h0001_0000, 1'b1, 16'h0000, 16'h0000, 4};
    vecs[1] = '{3'd6, 16'h1234, 16'h0100, 3'd7, 32'h0012_3400, 1'b0, 16'h3400, 16'h0012, 5};
    vecs[2] = '{3'd0, 16'hF0F0, 16'h0FF0, 3'd4, 32'h0000_00F0, 1'b0, 16'h00F0, 16'h0000, 4};
    vecs[3] = '{3'd1, 16'hF0F0, 16'h0FF0, 3'd4, 32'h0000_FFF0, 1'b0, 16'hFFF0, 16'h0000, 4};
    vecs[4] = '{3'd2, 16'hF0F0, 16'h0FF0, 3'd5, 32'h0000_FF00, 1'b0, 16'hFF00, 16'h0000, 4};
    vecs[5] = '{3'd5, 16'h8000, 16'h0004, 3'd6, 32'h0000_0800, 1'b0, 16'h0800, 16'h0000, 4};
    vecs[6] = '{3'd4, 16'h1234, 16'h0008, 3'd6, 32'h0012_3400, 1'b0, 16'h3400, 16'h0012, 5};
    vecs[7] = '{3'd7, 16'h0064, 16'h0007, 3'd5, 32'h0002_000E, 1'b1, 16'h000E, 16'h0000, 4};
    vecs[8] = '{3'd3, 16'h0003, 16'h0004, 3'd0, 32'h0000_0007, 1'b0, 16'h0007, 16'h0000, 4};

    reset = 1'b1; req_valid = 1'b0; req_cmd = '0; req_src1 = '0; req_src2 = '0;
    req_dst = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; force_cf = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_alu_in1", {16'h0, alu_in1}, 32'h0);
    rreg(3'd0, rv);
    chk("reset_r0", {16'h0, rv}, 32'h0);

    // Table-driven operations with r1/r2 as sources.
    for (int v = 0; v < 9; v++) begin
      wreg(3'd1, vecs[v].a);
      wreg(3'd2, vecs[v].b);
      do_op(vecs[v].cmd, 3'd1, 3'd2, vecs[v].dst, 1'b0, lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].lat));
      chk($sformatf("v%0d_result", v), rsp_result, vecs[v].res);
      chk($sformatf("v%0d_cf", v), {31'h0, rsp_cf}, {31'h0, vecs[v].cf});
      chk($sformatf("v%0d_err", v), {31'h0, rsp_err}, 32'h0);
      @(negedge clk);
      rreg(vecs[v].dst, rv);
      chk($sformatf("v%0d_dst", v), {16'h0, rv}, {16'h0, vecs[v].lo});
      if (vecs[v].lat == 5) begin
        rreg(vecs[v].dst + 3'd1, rv);
        chk($sformatf("v%0d_dst_plus1", v), {16'h0, rv}, {16'h0, vecs[v].hi});
      end
    end

    // Divide by zero: error, zero result, destination untouched.
    wreg(3'd4, 16'h00AA);
    wreg(3'd5, 16'h0000);
    wreg(3'd6, 16'h5555);
    do_op(3'd7, 3'd4, 3'd5, 3'd6, 1'b0, lat);
    chk("div0_latency", 32'(lat), 32'd4);
    chk("div0_err", {31'h0, rsp_err}, 32'h1);
    chk("div0_result", rsp_result, 32'h0);
    chk("div0_cf", {31'h0, rsp_cf}, 32'h0);
    @(negedge clk);
    rreg(3'd6, rv);
    chk("div0_r6", {16'h0, rv}, 32'h0000_5555);

    // ALU carry forced high: MUL passes it through, XOR ignores it.
    force_cf = 1'b1;
    wreg(3'd1, 16'h0002);
    wreg(3'd2, 16'h0003);
    do_op(3'd6, 3'd1, 3'd2, 3'd3, 1'b0, lat);
    chk("mulcf_cf", {31'h0, rsp_cf}, 32'h1);
    chk("mulcf_result", rsp_result, 32'h0000_0006);
    wreg(3'd1, 16'hF0F0);
    wreg(3'd2, 16'h0FF0);
    do_op(3'd2, 3'd1, 3'd2, 3'd3, 1'b0, lat);
    chk("xor_after_cf_cf", {31'h0, rsp_cf}, 32'h0);
    chk("xor_after_cf_result", rsp_result, 32'h0000_FF00);
    force_cf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rsp_result_held", rsp_result, 32'h0000_FF00);

    // External write during EXEC is ignored.
    wreg(3'd1, 16'h0011);
    wreg(3'd2, 16'h0022);
    do_op(3'd3, 3'd1, 3'd2, 3'd3, 1'b1, lat);
    chk("poke_result", rsp_result, 32'h0000_0033);
    @(negedge clk);
    rreg(3'd1, rv);
    chk("poke_r1_unchanged", {16'h0, rv}, 32'h0000_0011);

    // Back-to-back: req_valid held high across two requests.
    wreg(3'd1, 16'h0003);
    wreg(3'd2, 16'h0004);
    @(negedge clk);
    req_cmd = 3'd3; req_src1 = 3'd1; req_src2 = 3'd2; req_dst = 3'd3; req_valid = 1'b1;
    na = 0; rsp1 = -1; i = 0;
    while (na < 2 && i < 40) begin
      if (req_ready) begin acc[na] = i; na++; end
      if (rsp_valid && rsp1 < 0) rsp1 = i;
      if (na < 2) begin @(negedge clk); i++; end
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("b2b_accept_count", 32'(na), 32'd2);
    chk("b2b_first_rsp", 32'(rsp1), 32'd5);
    chk("b2b_second_accept", 32'(acc[1]), 32'(rsp1 + 1));
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clk); k++; end
    chk("b2b_second_rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("b2b_second_result", rsp_result, 32'h0000_0007);

    // Reset asserted mid-EXEC of an ADD.
    wreg(3'd1, 16'h0005);
    wreg(3'd2, 16'h0006);
    @(negedge clk);
    req_cmd = 3'd3; req_src1 = 3'd1; req_src2 = 3'd2; req_dst = 3'd3; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {31'h0, busy}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midreset_busy", {31'h0, busy}, 32'h0);
    chk("midreset_alu_in1", {16'h0, alu_in1}, 32'h0);
    chk("midreset_rsp_result", rsp_result, 32'h0);
    for (int r = 0; r < 8; r++) begin
      rreg(3'(r), rv);
      chk($sformatf("midreset_r%0d", r), {16'h0, rv}, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", {31'h0, req_ready}, 32'h1);
    k = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) k++;
    end
    chk("post_reset_no_rsp", 32'(k), 32'd0);
    rreg(3'd3, rv);
    chk("post_reset_r3", {16'h0, rv}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mcpu_alu_sequencer.md
# mcpu_alu_sequencer

Initiator side of the MCPU ALU command interface. It accepts one operation request at a time over a valid/ready handshake and reads both operands from an internal 8×16 register file. It drives the combinational ALU's `cmd`/`in1`/`in2` inputs, waits a fixed settle time, captures the 32-bit result and carry, writes the result back to the register file and pulses a response. It sits between the MCPU decode stage and the ALU.

## Interface
- `CMD_SIZE`, 3, ALU command width
- `WORD_SIZE`, 16, operand/register width; ALU result is 2·WORD_SIZE
- `REG_ADDR`, 3, register file address width (8 entries)
- `SETTLE`, 2, cycles `alu_cmd`/`alu_in1`/`alu_in2` are held stable before capture (≥1)

Ports:
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `req_valid` in 1 — request present
- `req_ready` out 1 — high only in IDLE
- `req_cmd` in CMD_SIZE — AND=0, OR=1, XOR=2, ADD=3, LSL=4, LSR=5, MUL=6, DIV=7
- `req_src1`, `req_src2`, `req_dst` in REG_ADDR — operand and destination registers
- `wr_en` in 1, `wr_addr` in REG_ADDR, `wr_data` in WORD_SIZE — external register load
- `rd_addr` in REG_ADDR, `rd_data` out WORD_SIZE — combinational register observe
- `alu_cmd` out CMD_SIZE, `alu_in1` out WORD_SIZE, `alu_in2` out WORD_SIZE — registered drive to ALU
- `alu_out` in 2·WORD_SIZE, `alu_cf` in 1 — ALU result
- `rsp_valid` out 1 — one-cycle completion pulse
- `rsp_result` out 2·WORD_SIZE, `rsp_cf` out 1, `rsp_err` out 1 — valid while `rsp_valid` is high
- `busy` out 1 — high in any state other than IDLE

## Operation
- FSM states: IDLE → READ → EXEC → WB_LO → [WB_HI] → RESP → IDLE.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch cmd/src1/src2/dst and go to READ.
- READ, 1 cycle: register the operand regs into `alu_in1`/`alu_in2` and the command into `alu_cmd`.
- EXEC, SETTLE cycles, counted by a down-counter. On the edge leaving EXEC, capture `alu_out` into a result register and compute the carry:
  - AND/OR/XOR: 0
  - ADD/LSR/DIV: |alu_out[31:16]
  - MUL/LSL: `alu_cf`
- Divide error: DIV with `alu_in2`==0 sets err=1 and forces result=0. No writeback occurs; the FSM goes through WB_LO doing nothing, then to RESP.
- WB_LO: write result[15:0] to dst.
- WB_HI: entered only for MUL/LSL; writes result[31:16] to (dst+1) mod 8, wrapping 7→0.
- RESP: `rsp_valid`=1 for exactly one cycle. `rsp_*` stay stable until the next RESP.
- External writes are honoured only in IDLE and ignored otherwise. A write and a request accept in the same IDLE cycle: the write commits first, and READ sees the new value.
- src1 or src2 equal to dst is legal; operands are read before writeback.
- `rd_data` reflects the register array, including writes from the previous edge.

## Timing
- Counting from the accept edge, `rsp_valid` is high in cycle:
  - SETTLE+2 for narrow ops (4 at default)
  - SETTLE+3 for MUL/LSL (5 at default)
- `req_ready` is low from the cycle after accept through RESP, and returns high the cycle after RESP. Sustained back-to-back throughput is one op per SETTLE+4 cycles (narrow).
- `alu_*` outputs are held constant from READ exit through WB_LO exit.
- Reset, applied asynchronously in any state including mid-EXEC:
  - state → IDLE
  - all 8 registers → 0
  - `alu_cmd`/`alu_in1`/`alu_in2` → 0
  - result, `rsp_result`, `rsp_cf`, `rsp_err`, `rsp_valid`, `busy` → 0
  - `req_ready` → 1 once reset deasserts
  - the interrupted op is discarded and nothing is written back

## Structure
- Shared package `mcpu_pkg`: CMD_* codes, WORD_SIZE/CMD_SIZE defaults, FSM state encoding, and the `is_wide(cmd)` helper (MUL/LSL).
- Sub-module `mcpu_regfile`: 8×WORD_SIZE, async reset-to-zero, one combinational read port for observe and two for operands, one write port. The FSM muxes the write port between the external load and writeback.

## Test plan
- r1=0xFFFF, r2=0x0001, ADD dst=r3 → `rsp_result`=0x0001_0000, `rsp_cf`=1, r3=0x0000, `rsp_valid` in accept cycle +4.
- r1=0x1234, r2=0x0100, MUL dst=r7 → r7=0x3400, r0=0x0012 (wrap), `rsp_cf`=0, `rsp_valid` at +5.
- r4=0x00AA, r5=0, DIV dst=r6 with r6=0x5555 → `rsp_err`=1, `rsp_result`=0, r6 still 0x5555.
- MUL producing `alu_cf`=1 (forced by an ALU model), then XOR 0xF0F0^0x0FF0 → `rsp_cf`=0, result 0xFF00.
- `req_valid` held high across two requests → second accepted only on the cycle after the first RESP. `wr_en` pulsed during EXEC → register unchanged.
- Assert `reset` during EXEC of an ADD → `rsp_valid` never fires, all registers read 0, `req_ready`=1 after release.
